ternary_sign_mag_decoder: RTL and testbench



---
 rtl/ternary_sign_mag_decoder.sv | 234 +++++++++++++++++++++++
 tb/tb_ternary_sign_mag_decoder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ternary_sign_mag_decoder.sv
// ---------------------------------------------------------------------------
// ternary_sign_mag_decoder
//
// Converts a 3-digit radix-3 complement word into sign + unsigned ternary
// magnitude. Each digit is packed in 2 bits (0..2, 2'b11 is illegal). The
// conversion runs digit-serially, least significant digit first, over three
// cycles. A single word is in flight at a time.
//
// Ports
//   clk           rising-edge clock for all state
//   resetN        asynchronous active-low reset
//   inValid       producer presents a word on inWord
//   inWord[5:0]   radix-3 complement word, [5:4] = sign digit, [1:0] = LSD
//   inReady       block can accept a word (high only while idle)
//   outValid      result fields are valid
//   outReady      consumer accepts the result
//   sign          1 = negative
//   mag[5:0]      unsigned ternary magnitude, same digit packing as inWord
//   overflow      sign digit was 1 (out-of-range encoding)
//   invalidDigit  some digit of the captured word was 2'b11
// ---------------------------------------------------------------------------
module ternary_sign_mag_decoder (
  input  logic       clk,
  input  logic       resetN,
  input  logic       inValid,
  input  logic [5:0] inWord,
  output logic       inReady,
  output logic       outValid,
  input  logic       outReady,
  output logic       sign,
  output logic [5:0] mag,
  output logic       overflow,
  output logic       invalidDigit
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_D0   = 3'd1,
    ST_D1   = 3'd2,
    ST_D2   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // One step of the serial "27 - N" subtraction.
  // Returns {carry_out, result_digit}. An illegal digit yields zero; the
  // result is masked later anyway.
  function automatic logic [2:0] neg_digit(input logic [1:0] d, input logic cin);
    logic [2:0] t;
    logic [2:0] r;
    t = 3'd0;
    r = 3'b000;
    if (d == 2'b11) begin
      r = 3'b000;
    end else begin
      t = (3'd2 - {1'b0, d}) + {2'b00, cin};
      if (t >= 3'd3) begin
        t = t - 3'd3;
        r = {1'b1, t[1:0]};
      end else begin
        r = {1'b0, t[1:0]};
      end
    end
    return r;
  endfunction

  // State and working registers
  state_t     state_q, state_d;
  logic [5:0] word_q, word_d;
  logic [5:0] acc_q, acc_d;
  logic       carry_q, carry_d;
  logic       inv_q, inv_d;

  // Registered outputs
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       sign_q, sign_d;
  logic [5:0] mag_q, mag_d;
  logic       overflow_q, overflow_d;
  logic       invalid_q, invalid_d;

  // Digit datapath signals
  logic [1:0] cur_digit_s;
  logic       cin_s;
  logic       neg_s;
  logic       ovf_s;
  logic [2:0] neg_res_s;
  logic [1:0] dig_out_s;
  logic       carry_next_s;
  logic       digit_bad_s;
  logic       inv_final_s;

  // Select the digit handled in the current serial step and convert it
  always_comb begin
    cur_digit_s = 2'b00;
    case (state_q)
      ST_D0:   cur_digit_s = word_q[1:0];
      ST_D1:   cur_digit_s = word_q[3:2];
      ST_D2:   cur_digit_s = word_q[5:4];
      default: cur_digit_s = 2'b00;
    endcase

    // The "+1" of the complement enters as the carry into digit 0.
    if (state_q == ST_D0) begin
      cin_s = 1'b1;
    end else begin
      cin_s = carry_q;
    end

    neg_s     = (word_q[5:4] == 2'd2);
    ovf_s     = (word_q[5:4] == 2'd1);
    neg_res_s = neg_digit(cur_digit_s, cin_s);

    if (neg_s) begin
      dig_out_s    = neg_res_s[1:0];
      carry_next_s = neg_res_s[2];
    end else begin
      dig_out_s    = cur_digit_s;
      carry_next_s = 1'b0;
    end

    digit_bad_s = (cur_digit_s == 2'b11);
    inv_final_s = inv_q | digit_bad_s;
  end

  // Next-state and next-output logic for the serial decoder
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    inv_d       = inv_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    overflow_d  = overflow_q;
    invalid_d   = invalid_q;

    case (state_q)
      ST_IDLE: begin
        if (inValid && in_ready_q) begin
          word_d     = inWord;
          acc_d      = 6'b000000;
          carry_d    = 1'b0;
          inv_d      = 1'b0;
          in_ready_d = 1'b0;
          state_d    = ST_D0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_D0: begin
        acc_d[1:0] = dig_out_s;
        carry_d    = carry_next_s;
        inv_d      = inv_final_s;
        state_d    = ST_D1;
      end
      ST_D1: begin
        acc_d[3:2] = dig_out_s;
        carry_d    = carry_next_s;
        inv_d      = inv_final_s;
        state_d    = ST_D1 == ST_D1 ? ST_D2 : ST_D2;
      end
      ST_D2: begin
        acc_d[5:4] = dig_out_s;
        carry_d    = carry_next_s;
        inv_d      = inv_final_s;
        // Result fields only change here, so they hold across the
        // handshake and until the next word finishes.
        invalid_d  = inv_final_s;
        overflow_d = ovf_s;
        sign_d     = neg_s & ~inv_final_s;
        if (inv_final_s || ovf_s) begin
          mag_d = 6'b000000;
        end else begin
          mag_d = {dig_out_s, acc_q[3:0]};
        end
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (outReady) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State, working and output registers with asynchronous reset
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      word_q      <= 6'b000000;
      acc_q       <= 6'b000000;
      carry_q     <= 1'b0;
      inv_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sign_q      <= 1'b0;
      mag_q       <= 6'b000000;
      overflow_q  <= 1'b0;
      invalid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      inv_q       <= inv_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      overflow_q  <= overflow_d;
      invalid_q   <= invalid_d;
    end
  end

  assign inReady      = in_ready_q;
  assign outValid     = out_valid_q;
  assign sign         = sign_q;
  assign mag          = mag_q;
  assign overflow     = overflow_q;
  assign invalidDigit = invalid_q;

endmodule

// File: tb/tb_ternary_sign_mag_decoder.sv
module tb_ternary_sign_mag_decoder;

  logic       clk;
  logic       resetN;
  logic       inValid;
  logic [5:0] inWord;
  logic       inReady;
  logic       outValid;
  logic       outReady;
  logic       sign;
  logic [5:0] mag;
  logic       overflow;
  logic       invalidDigit;

  int n_cmp  = 0;
  int n_fail = 0;

  // expected result packing: {sign, mag[5:0], overflow, invalidDigit}
  logic [8:0] sb_q[$];

  ternary_sign_mag_decoder dut (
    .clk          (clk),
    .resetN       (resetN),
    .inValid      (inValid),
    .inWord       (inWord),
    .inReady      (inReady),
    .outValid     (outValid),
    .outReady     (outReady),
    .sign         (sign),
    .mag          (mag),
    .overflow     (overflow),
    .invalidDigit (invalidDigit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected result per output transfer
  always @(negedge clk) begin
    if (resetN && outValid && outReady) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = sb_q.pop_front();
        chk("result", {23'd0, sign, mag, overflow, invalidDigit}, {23'd0, e});
      end
    end
  end

  // Issue one word, queue its expectation and check the latency profile.
  // Returns #1 after the edge that enters DONE.
  task automatic send(input logic [5:0] w, input logic [8:0] exp);
    int guard;
    guard = 0;
    while (!inReady && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!inReady) chk("ready_timeout", 32'd0, 32'd1);
    sb_q.push_back(exp);
    inValid = 1'b1;
    inWord  = w;
    @(posedge clk); #1;            // transfer edge k
    inValid = 1'b0;
    inWord  = 6'b111111;           // must not be resampled
    chk("busy_not_ready", {31'd0, inReady}, 32'd0);
    chk("lat_k0", {31'd0, outValid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_k1", {31'd0, outValid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_k2", {31'd0, outValid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_k3", {31'd0, outValid}, 32'd1);
  endtask

  initial begin
    resetN   = 1'b1;
    inValid  = 1'b0;
    inWord   = 6'b000000;
    outReady = 1'b1;
    #1 resetN = 1'b0;
    #2;
    chk("rst_outs", {23'd0, outValid, sign, mag, overflow, invalidDigit}, 32'd0);
    #19 resetN = 1'b1;             // released mid-cycle at t=22
    @(posedge clk); #1;
    chk("rst_ready", {31'd0, inReady}, 32'd1);

    // Directed vectors
    send(6'b100101, {1'b1, 6'b000110, 1'b0, 1'b0});   // -5
    send(6'b100000, {1'b1, 6'b010000, 1'b0, 1'b0});   // -9, carry ripples
    send(6'b001010, {1'b0, 6'b001010, 1'b0, 1'b0});   // +8
    @(posedge clk); #1;                                // back in IDLE
    chk("hold_after_xfer", {24'd0, sign, mag, overflow}, {24'd0, 1'b0, 6'b001010, 1'b0});
    chk("idle_ready", {31'd0, inReady}, 32'd1);
    send(6'b000000, {1'b0, 6'b000000, 1'b0, 1'b0});   // 0
    send(6'b011001, {1'b0, 6'b000000, 1'b1, 1'b0});   // overflow
    send(6'b000011, {1'b0, 6'b000000, 1'b0, 1'b1});   // illegal LSD
    send(6'b011111, {1'b0, 6'b000000, 1'b1, 1'b1});   // overflow + illegal
    send(6'b110000, {1'b0, 6'b000000, 1'b0, 1'b1});   // illegal sign digit
    send(6'b101010, {1'b1, 6'b000001, 1'b0, 1'b0});   // -1
    send(6'b100001, {1'b1, 6'b001010, 1'b0, 1'b0});   // -8

    // Backpressure: DONE held 5 cycles, inValid pulses ignored
    @(posedge clk); #1;
    outReady = 1'b0;
    send(6'b100101, {1'b1, 6'b000110, 1'b0, 1'b0});
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, outValid}, 32'd1);
      chk("bp_ready", {31'd0, inReady}, 32'd0);
      chk("bp_fields", {23'd0, sign, mag, overflow, invalidDigit},
          {23'd0, 1'b1, 6'b000110, 1'b0, 1'b0});
      if (i == 1 || i == 3) begin
        inValid = 1'b1;
        inWord  = 6'b011001;
      end else begin
        inValid = 1'b0;
      end
      @(posedge clk); #1;
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {30'd0, outValid, inReady}, {30'd0, 1'b0, 1'b1});

    // Reset pulsed during D1 aborts the operation
    inValid = 1'b1;
    inWord  = 6'b100000;
    @(posedge clk); #1;            // -> D0
    inValid = 1'b0;
    @(posedge clk); #1;            // -> D1
    #2 resetN = 1'b0;
    #1;
    chk("abort_outs", {23'd0, outValid, sign, mag, overflow, invalidDigit}, 32'd0);
    @(posedge clk); #1;
    chk("abort_hold", {31'd0, outValid}, 32'd0);
    @(negedge clk); #1;
    resetN = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready", {31'd0, inReady}, 32'd1);
    send(6'b100101, {1'b1, 6'b000110, 1'b0, 1'b0});   // fresh word after abort

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
